craps_sequencer: RTL

Game-flow controller for the two-die craps board. Turns the raw roll pushbutton into a debounced press/release, drives the dice datapath's `roll_en` while the button is held, and samples the frozen two-die sum after release. Applies come-out and point rules and holds point, win/lose and roll count for the display logic. Sits between the board buttons and the dice counter / seven-segment datapath.

---
 rtl/craps_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/craps_sequencer.sv
// Craps game-flow controller: debounces the roll button, gates the dice counters
// while it is held, and scores come-out and point rolls from the frozen dice sum.
module craps_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       rb_raw,
    input  logic [3:0] sum_in,
    output logic       roll_en,
    output logic [3:0] point,
    output logic       point_valid,
    output logic       win,
    output logic       lose,
    output logic [3:0] roll_count,
    output logic       err
);

    localparam logic [15:0] CntLast = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ROLL1,
        EVAL1,
        POINT,
        ROLLN,
        EVALN,
        DONE
    } state_t;

    logic        syncMeta_q;
    logic        syncOut_q;
    logic        db_q;
    logic        db_d;
    logic        dbPrev_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    state_t      state_q;
    logic        rollEn_q;
    logic [3:0]  point_q;
    logic        pointValid_q;
    logic        win_q;
    logic        lose_q;
    logic [3:0]  rollCount_q;
    logic        err_q;

    logic        press;
    logic        release_;
    logic        sumLegal;
    logic [3:0]  countInc;

    // The level only flips after an unbroken run of differing samples; any agreeing sample restarts the run.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (syncOut_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            db_d  = ~db_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            syncMeta_q <= 1'b0;
            syncOut_q  <= 1'b0;
            db_q       <= 1'b0;
            dbPrev_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            syncMeta_q <= rb_raw;
            syncOut_q  <= syncMeta_q;
            db_q       <= db_d;
            dbPrev_q   <= db_q;
            cnt_q      <= cnt_d;
        end
    end

    assign press    = db_q & ~dbPrev_q;
    assign release_ = ~db_q & dbPrev_q;
    assign sumLegal = (sum_in >= 4'd2) && (sum_in <= 4'd12);
    assign countInc = (rollCount_q == 4'd15) ? rollCount_q : rollCount_q + 4'd1;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            rollEn_q     <= 1'b0;
            point_q      <= '0;
            pointValid_q <= 1'b0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            rollCount_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (press) begin
                        state_q  <= ROLL1;
                        rollEn_q <= 1'b1;
                    end
                end
                ROLL1: begin
                    if (release_) begin
                        state_q  <= EVAL1;
                        rollEn_q <= 1'b0;
                    end
                end
                EVAL1: begin
                    if (!sumLegal) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        rollCount_q <= countInc;
                        case (sum_in)
                            4'd7, 4'd11: begin
                                win_q   <= 1'b1;
                                state_q <= DONE;
                            end
                            4'd2, 4'd3, 4'd12: begin
                                lose_q  <= 1'b1;
                                state_q <= DONE;
                            end
                            default: begin
                                point_q      <= sum_in;
                                pointValid_q <= 1'b1;
                                state_q      <= POINT;
                            end
                        endcase
                    end
                end
                POINT: begin
                    if (press) begin
                        state_q  <= ROLLN;
                        rollEn_q <= 1'b1;
                    end
                end
                ROLLN: begin
                    if (release_) begin
                        state_q  <= EVALN;
                        rollEn_q <= 1'b0;
                    end
                end
                EVALN: begin
                    if (!sumLegal) begin
                        err_q   <= 1'b1;
                        state_q <= POINT;
                    end else begin
                        rollCount_q <= countInc;
                        // The point value stays on the display after the game ends; only the valid flag drops.
                        if (sum_in == point_q) begin
                            win_q        <= 1'b1;
                            pointValid_q <= 1'b0;
                            state_q      <= DONE;
                        end else if (sum_in == 4'd7) begin
                            lose_q       <= 1'b1;
                            pointValid_q <= 1'b0;
                            state_q      <= DONE;
                        end else begin
                            state_q <= POINT;
                        end
                    end
                end
                DONE: begin
                    if (press) begin
                        win_q        <= 1'b0;
                        lose_q       <= 1'b0;
                        point_q      <= '0;
                        pointValid_q <= 1'b0;
                        rollCount_q  <= '0;
                        rollEn_q     <= 1'b1;
                        state_q      <= ROLL1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    rollEn_q <= 1'b0;
                end
            endcase
        end
    end

    assign roll_en     = rollEn_q;
    assign point       = point_q;
    assign point_valid = pointValid_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign roll_count  = rollCount_q;
    assign err         = err_q;

endmodule
